lane_pipe_skid: RTL



---
 rtl/lane_pipe_skid_if.sv | 32 +++
 rtl/lane_pipe_skid.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/lane_pipe_skid_if.sv
// Valid/ready bundle for lane_pipe_skid.
// The master modport is the environment around the block, and the slave
// modport is the block itself.
//
// Handshake semantics (both directions):
//   A beat moves across a boundary on the posedge where valid && ready.
//   Once valid is high, the sender holds the beat until it is taken.
//   Ready never depends combinationally on valid.
//   in_data lane i occupies bits [i*DATA_W +: DATA_W]. in_lmask[i] enables lane i.
interface lane_pipe_skid_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic [LANES-1:0]        in_lmask;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic [LANES-1:0]        out_lmask;

    modport master (
        output in_valid, in_data, in_lmask, out_ready,
        input  in_ready, out_valid, out_data, out_lmask
    );

    modport slave (
        input  in_valid, in_data, in_lmask, out_ready,
        output in_ready, out_valid, out_data, out_lmask
    );
endinterface

// File: rtl/lane_pipe_skid.sv
// lane_pipe_skid: a multi-lane pipeline register with valid/ready backpressure.
// The block is built from STAGES skid stages. Each stage holds a main register
// and a skid register. Each register stores the data and the lane mask of one beat.
// A stage's ready comes only from its own registered state, so no combinational
// ready path runs across the stages.
// Optional feature macro: LANE_PIPE_SKID_STATS_EN. When this macro is defined,
// the block adds two saturating counters, stall_cnt and xfer_cnt.
module lane_pipe_skid #(
    parameter  int LANES  = 4,
    parameter  int DATA_W = 8,
    parameter  int STAGES = 2,
    localparam int OCC_W  = $clog2(2*STAGES+1)
) (
    input  logic                clk,
    input  logic                reset,
    lane_pipe_skid_if.slave     bus,
    output logic [OCC_W-1:0]    occupancy,
    output logic [2*STAGES-1:0] stage_state
`ifdef LANE_PIPE_SKID_STATS_EN
    ,
    output logic [15:0]         stall_cnt,
    output logic [15:0]         xfer_cnt
`endif
);

    localparam int DW     = LANES*DATA_W;
    localparam int BEAT_W = DW + LANES;   // {mask, data}

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_BUSY  = 2'd1,
        S_FULL  = 2'd2
    } stage_t;

    stage_t            state_q [STAGES];
    logic [BEAT_W-1:0] main_q  [STAGES];
    logic [BEAT_W-1:0] skid_q  [STAGES];
    logic [BEAT_W-1:0] beat_in [STAGES];

    // ready_chain[k] and valid_chain[k] describe the boundary into stage k.
    // Index STAGES is the downstream port.
    logic [STAGES:0]   ready_chain;
    logic [STAGES:0]   valid_chain;
    logic [STAGES-1:0] accept;
    logic [STAGES-1:0] take;

    logic [BEAT_W-1:0] out_beat;
    logic [DW-1:0]     out_data_w;
    logic              up_xfer;
    logic              dn_xfer;
    logic [OCC_W-1:0]  occ_q;

    // Handshake chain: ready comes from the registered state, and valid means the previous stage holds a beat
    always_comb begin
        ready_chain = '0;
        valid_chain = '0;
        accept      = '0;
        take        = '0;
        for (int k = 0; k < STAGES; k++) begin
            ready_chain[k]   = (state_q[k] != S_FULL);
            valid_chain[k+1] = (state_q[k] != S_EMPTY);
        end
        ready_chain[STAGES] = bus.out_ready;
        valid_chain[0]      = bus.in_valid;
        for (int k = 0; k < STAGES; k++) begin
            accept[k] = valid_chain[k]   && ready_chain[k];
            take[k]   = valid_chain[k+1] && ready_chain[k+1];
        end
    end

    // Beat presented to each stage: the upstream port for stage 0, and the previous main register for the other stages
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            beat_in[k] = '0;
        end
        beat_in[0] = {bus.in_lmask, bus.in_data};
        for (int k = 1; k < STAGES; k++) begin
            beat_in[k] = main_q[k-1];
        end
    end

    // Per-stage EMPTY/BUSY/FULL state machine with its main and skid registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                state_q[k] <= S_EMPTY;
                main_q[k]  <= '0;
                skid_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                case (state_q[k])
                    S_EMPTY: begin
                        if (accept[k]) begin
                            main_q[k]  <= beat_in[k];
                            state_q[k] <= S_BUSY;
                        end
                    end
                    S_BUSY: begin
                        if (accept[k] && take[k]) begin
                            main_q[k] <= beat_in[k];
                        end else if (accept[k]) begin
                            // The downstream stage stalled, so the new beat waits in the skid register
                            skid_q[k]  <= beat_in[k];
                            state_q[k] <= S_FULL;
                        end else if (take[k]) begin
                            state_q[k] <= S_EMPTY;
                        end
                    end
                    S_FULL: begin
                        if (take[k]) begin
                            main_q[k]  <= skid_q[k];
                            skid_q[k]  <= '0;
                            state_q[k] <= S_BUSY;
                        end
                    end
                    default: state_q[k] <= S_EMPTY;
                endcase
            end
        end
    end

    assign up_xfer = bus.in_valid && ready_chain[0];
    assign dn_xfer = valid_chain[STAGES] && bus.out_ready;

    // Occupancy counter: +1 on an upstream transfer, -1 on a downstream transfer, no change when both occur
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            case ({up_xfer, dn_xfer})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign out_beat = main_q[STAGES-1];

    // Output lane masking: a disabled lane reads as zero, and the stored data is not changed
    always_comb begin
        out_data_w = '0;
        for (int i = 0; i < LANES; i++) begin
            if (out_beat[DW+i]) begin
                out_data_w[i*DATA_W +: DATA_W] = out_beat[i*DATA_W +: DATA_W];
            end
        end
    end

    // Debug view of every stage state, with stage k in bits [2k+1:2k]
    always_comb begin
        stage_state = '0;
        for (int k = 0; k < STAGES; k++) begin
            stage_state[2*k +: 2] = state_q[k];
        end
    end

    assign bus.in_ready  = ready_chain[0];
    assign bus.out_valid = valid_chain[STAGES];
    assign bus.out_data  = out_data_w;
    assign bus.out_lmask = out_beat[BEAT_W-1 -: LANES];
    assign occupancy     = occ_q;

`ifdef LANE_PIPE_SKID_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] xfer_q;

    // Saturating count of cycles where the output is valid but not accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if (valid_chain[STAGES] && !bus.out_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    // Saturating count of downstream transfers
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_q <= '0;
        end else if (dn_xfer && xfer_q != 16'hFFFF) begin
            xfer_q <= xfer_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign xfer_cnt  = xfer_q;
`endif

endmodule
